// File: rtl/pet_pkg.sv
// Shared types, command codes and decode helpers for the pet update scheduler.
package pet_pkg;

    typedef enum logic [2:0] {
        HUNGER    = 3'd0,
        HAPPINESS = 3'd1,
        HEALTH    = 3'd2,
        HYGIENE   = 3'd3,
        ENERGY    = 3'd4
    } stat_sel_e;

    typedef enum logic [1:0] {AWAKE, SLEEPING, DEAD} game_state_e;

    typedef enum logic [1:0] {IDLE, CMD, TICK_RND, TICK_NRG} issue_state_e;

    typedef struct packed {
        logic      valid;
        stat_sel_e sel;
    } stat_op_t;

    localparam logic [7:0] CMD_EAT   = 8'h65;
    localparam logic [7:0] CMD_PLAY  = 8'h70;
    localparam logic [7:0] CMD_HEAL  = 8'h64;
    localparam logic [7:0] CMD_BATH  = 8'h62;
    localparam logic [7:0] CMD_SLEEP = 8'h73;
    localparam logic [7:0] CMD_WAKE  = 8'h77;

    // Button codes that decrement a stat; sleep/wake are handled by the game FSM.
    function automatic stat_op_t decode_cmd(input logic [7:0] code);
        stat_op_t op;
        op.valid = 1'b1;
        op.sel   = HUNGER;
        case (code)
            CMD_EAT:  op.sel = HUNGER;
            CMD_PLAY: op.sel = HAPPINESS;
            CMD_HEAL: op.sel = HEALTH;
            CMD_BATH: op.sel = HYGIENE;
            default:  op.valid = 1'b0;
        endcase
        return op;
    endfunction

    function automatic stat_op_t decode_random(input logic [2:0] rnd);
        stat_op_t op;
        op.valid = 1'b1;
        op.sel   = HUNGER;
        case (rnd)
            3'b001:  op.sel = HUNGER;
            3'b000:  op.sel = HAPPINESS;
            3'b010:  op.sel = HEALTH;
            3'b011:  op.sel = HYGIENE;
            3'b110:  op.sel = ENERGY;
            default: op.valid = 1'b0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Game tick generator: free-running counter with a one-cycle tick in the wrap cycle
// and a phase bit that toggles on every tick.
module pet_tick_gen #(
    parameter int TICK_CYCLES = 27_000_000,
    parameter int CNT_W       = 28
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic second
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            second <= 1'b0;
        end else if (tick) begin
            count  <= '0;
            second <= ~second;
        end else begin
            count  <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pet_update_scheduler.sv
// Sequences all stat updates: decodes buttons, captures tick ops, arbitrates them onto
// one valid/ready port and owns the AWAKE/SLEEPING/DEAD game state.
module pet_update_scheduler
    import pet_pkg::*;
#(
    parameter int TICK_CYCLES = 27_000_000,
    parameter int CNT_W       = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inputs,
    input  logic [7:0] random,
    input  logic       stats_all_zero,
    input  logic       upd_ready,
    output logic       upd_valid,
    output logic [2:0] upd_sel,
    output logic       upd_dir,
    output logic       second,
    output logic       is_sleeping,
    output logic       is_dead,
    output logic       tick_overrun
);

    logic tick;

    pet_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .second (second)
    );

    game_state_e  game_q, game_d;
    issue_state_e issue_q, issue_d;
    logic         armed_q;
    logic         cmd_pend_q, cmd_pend_d;
    stat_sel_e    cmd_sel_q, cmd_sel_d;
    logic         rnd_pend_q, rnd_pend_d;
    stat_sel_e    rnd_sel_q, rnd_sel_d;
    logic         nrg_pend_q, nrg_pend_d;
    logic         overrun_q;

    logic         accept, xfer, tick_full, tick_take;
    stat_op_t     cmd_op, rnd_op;
    logic         rnd_unused;

    assign accept     = armed_q && (inputs != 8'h00);
    assign xfer       = upd_valid && upd_ready;
    assign tick_full  = rnd_pend_q || nrg_pend_q;
    assign tick_take  = tick && !tick_full && (game_q != DEAD);
    assign cmd_op     = decode_cmd(inputs);
    assign rnd_op     = decode_random(random[2:0]);
    assign rnd_unused = ^random[7:3];

    always_comb begin
        game_d = game_q;
        if (stats_all_zero || game_q == DEAD) begin
            game_d = DEAD;
        end else if (accept && game_q == AWAKE && inputs == CMD_SLEEP) begin
            game_d = SLEEPING;
        end else if (accept && game_q == SLEEPING && inputs == CMD_WAKE) begin
            game_d = AWAKE;
        end
    end

    // An op stays in its slot until transferred, so a slot counts as full while in flight.
    always_comb begin
        cmd_pend_d = cmd_pend_q;
        cmd_sel_d  = cmd_sel_q;
        rnd_pend_d = rnd_pend_q;
        rnd_sel_d  = rnd_sel_q;
        nrg_pend_d = nrg_pend_q;
        issue_d    = issue_q;

        if (xfer) begin
            case (issue_q)
                CMD:      cmd_pend_d = 1'b0;
                TICK_RND: rnd_pend_d = 1'b0;
                TICK_NRG: nrg_pend_d = 1'b0;
                default:  ;
            endcase
        end

        if (accept && game_q == AWAKE && cmd_op.valid && !cmd_pend_q) begin
            cmd_pend_d = 1'b1;
            cmd_sel_d  = cmd_op.sel;
        end

        if (tick_take) begin
            rnd_pend_d = rnd_op.valid;
            rnd_sel_d  = rnd_op.sel;
            nrg_pend_d = (game_q == SLEEPING) && second;
        end

        if (issue_q == IDLE || xfer) begin
            if (cmd_pend_d)      issue_d = CMD;
            else if (rnd_pend_d) issue_d = TICK_RND;
            else if (nrg_pend_d) issue_d = TICK_NRG;
            else                 issue_d = IDLE;
        end

        if (game_d == DEAD) begin
            cmd_pend_d = 1'b0;
            rnd_pend_d = 1'b0;
            nrg_pend_d = 1'b0;
            issue_d    = IDLE;
        end
    end

    always_comb begin
        upd_valid = (issue_q != IDLE);
        upd_sel   = 3'd0;
        upd_dir   = 1'b0;
        case (issue_q)
            CMD:      upd_sel = cmd_sel_q;
            TICK_RND: begin
                upd_sel = rnd_sel_q;
                upd_dir = 1'b1;
            end
            TICK_NRG: upd_sel = ENERGY;
            default:  ;
        endcase
    end

    assign is_sleeping  = (game_q == SLEEPING);
    assign is_dead      = (game_q == DEAD);
    assign tick_overrun = overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            game_q     <= AWAKE;
            issue_q    <= IDLE;
            armed_q    <= 1'b1;
            cmd_pend_q <= 1'b0;
            cmd_sel_q  <= HUNGER;
            rnd_pend_q <= 1'b0;
            rnd_sel_q  <= HUNGER;
            nrg_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            game_q     <= game_d;
            issue_q    <= issue_d;
            armed_q    <= (inputs == 8'h00);
            cmd_pend_q <= cmd_pend_d;
            cmd_sel_q  <= cmd_sel_d;
            rnd_pend_q <= rnd_pend_d;
            rnd_sel_q  <= rnd_sel_d;
            nrg_pend_q <= nrg_pend_d;
            if (tick && tick_full) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pet_update_scheduler.sv
// Scoreboard bench for pet_update_scheduler with an 8-cycle game tick.
module tb_pet_update_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] inputs;
    logic [7:0] random;
    logic       stats_all_zero;
    logic       upd_ready;
    logic       upd_valid;
    logic [2:0] upd_sel;
    logic       upd_dir;
    logic       second;
    logic       is_sleeping;
    logic       is_dead;
    logic       tick_overrun;

    typedef struct {
        logic [2:0] sel;
        logic       dir;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pet_update_scheduler #(
        .TICK_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inputs         (inputs),
        .random         (random),
        .stats_all_zero (stats_all_zero),
        .upd_ready      (upd_ready),
        .upd_valid      (upd_valid),
        .upd_sel        (upd_sel),
        .upd_dir        (upd_dir),
        .second         (second),
        .is_sleeping    (is_sleeping),
        .is_dead        (is_dead),
        .tick_overrun   (tick_overrun)
    );

    always #5 clk = ~clk;

    // Every completed transfer must match the oldest expected op.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && upd_valid && upd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_op: got sel=%0d dir=%0d, required no transfer", upd_sel, upd_dir);
            end else begin
                e = exp_q.pop_front();
                if (upd_sel !== e.sel || upd_dir !== e.dir) begin
                    errors++;
                    $display("[TB] FAIL op_order: got sel=%0d dir=%0d, required sel=%0d dir=%0d",
                             upd_sel, upd_dir, e.sel, e.dir);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        nextCycle();
        inputs = code;
    endtask

    task automatic pushExp(input logic [2:0] sel, input logic dir);
        exp_t e;
        e.sel = sel;
        e.dir = dir;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge of the first cycle after a tick.
    task automatic waitSecondToggle();
        logic start;
        bit   seen;
        start = second;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (second !== start) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_timeout: got no toggle of second in 20 cycles, required one");
        end
    endtask

    initial begin
        logic pre;
        int   seen_valid;

        rst_n          = 1'b0;
        inputs         = 8'h00;
        random         = 8'h04;
        stats_all_zero = 1'b0;
        upd_ready      = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", upd_valid, 0);
        checkOutput("rst_sel", upd_sel, 0);
        checkOutput("rst_dir", upd_dir, 0);
        checkOutput("rst_second", second, 0);
        checkOutput("rst_sleeping", is_sleeping, 0);
        checkOutput("rst_dead", is_dead, 0);
        checkOutput("rst_overrun", tick_overrun, 0);

        // First tick with random 001 gives a single hunger+1 op.
        nextCycle();
        rst_n  = 1'b1;
        random = 8'h01;
        pushExp(3'd0, 1'b1);
        waitSecondToggle();
        checkOutput("t1_second", second, 1);
        checkOutput("t1_valid", upd_valid, 1);
        checkOutput("t1_sel", upd_sel, 0);
        checkOutput("t1_dir", upd_dir, 1);
        nextCycle();
        random = 8'h04;
        @(negedge clk);
        checkOutput("t1_drop", upd_valid, 0);

        // Held button issues once; release and press again issues once more.
        applyStimulus(8'h65);
        pushExp(3'd0, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_latency", upd_valid, 1);
        repeat (18) nextCycle();
        applyStimulus(8'h00);
        nextCycle();
        applyStimulus(8'h65);
        pushExp(3'd0, 1'b0);
        repeat (3) nextCycle();
        applyStimulus(8'h00);
        repeat (3) nextCycle();

        // Command and tick in the same cycle while the port is stalled.
        waitSecondToggle();
        repeat (7) nextCycle();
        upd_ready = 1'b0;
        inputs    = 8'h70;
        random    = 8'h01;
        pushExp(3'd1, 1'b0);
        pushExp(3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            inputs = 8'h00;
            random = 8'h04;
            @(negedge clk);
            checkOutput("t3_valid", upd_valid, 1);
            checkOutput("t3_sel", upd_sel, 1);
            checkOutput("t3_dir", upd_dir, 0);
        end
        nextCycle();
        upd_ready = 1'b1;
        repeat (4) nextCycle();

        // Sleep: stat commands ignored, energy-1 on every tick taken with second==1.
        waitSecondToggle();
        applyStimulus(8'h73);
        applyStimulus(8'h00);
        @(negedge clk);
        checkOutput("t4_sleeping", is_sleeping, 1);
        nextCycle();
        applyStimulus(8'h65);
        applyStimulus(8'h00);
        random = 8'h07;
        @(negedge clk);
        checkOutput("t4_eat_ignored", upd_valid, 0);
        for (int i = 0; i < 4; i++) begin
            pre = second;
            if (pre) pushExp(3'd4, 1'b0);
            waitSecondToggle();
        end
        applyStimulus(8'h77);
        applyStimulus(8'h00);
        random = 8'h04;
        @(negedge clk);
        checkOutput("t4_awake", is_sleeping, 0);

        // Stalled port across two ticks: second tick overruns and is dropped.
        nextCycle();
        upd_ready = 1'b0;
        random    = 8'h01;
        pushExp(3'd0, 1'b1);
        waitSecondToggle();
        waitSecondToggle();
        checkOutput("t5_overrun", tick_overrun, 1);
        nextCycle();
        random    = 8'h04;
        upd_ready = 1'b1;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("t5_overrun_sticky", tick_overrun, 1);
        checkOutput("t5_idle", upd_valid, 0);

        // Death aborts the pending op and blocks all later ops.
        nextCycle();
        upd_ready = 1'b0;
        random    = 8'h01;
        waitSecondToggle();
        checkOutput("t6_pending", upd_valid, 1);
        nextCycle();
        stats_all_zero = 1'b1;
        random         = 8'h04;
        nextCycle();
        stats_all_zero = 1'b0;
        @(negedge clk);
        checkOutput("t6_dead", is_dead, 1);
        checkOutput("t6_abort", upd_valid, 0);
        upd_ready  = 1'b1;
        random     = 8'h01;
        seen_valid = 0;
        applyStimulus(8'h65);
        applyStimulus(8'h00);
        applyStimulus(8'h73);
        applyStimulus(8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_valid) seen_valid++;
            nextCycle();
        end
        checkOutput("t6_no_ops", seen_valid, 0);
        checkOutput("t6_still_dead", is_dead, 1);

        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("t6_rst_dead", is_dead, 0);
        checkOutput("t6_rst_valid", upd_valid, 0);
        checkOutput("t6_rst_overrun", tick_overrun, 0);
        checkOutput("t6_rst_second", second, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
